// File: rtl/power_mon_pkg.sv
// Shared types and helpers for the switching-activity monitor.
// The saturating adder works on a fixed maximum width so it can serve any CNT_W up to 32.
package power_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        HOLD
    } state_t;

    localparam int DEF_WIDTH    = 1;
    localparam int DEF_WIN_LOG2 = 8;
    localparam int DEF_CNT_W    = 16;
    localparam int SAT_MAX_W    = 32;

    typedef struct packed {
        logic                 carry;
        logic [SAT_MAX_W-1:0] sum;
    } sat_result_t;

    // Adds two zero-extended operands and clamps the result to 2**width-1.
    // The carry flag reports that clamping happened.
    function automatic sat_result_t sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] limit;
        sat_result_t        res;
        full  = {1'b0, a} + {1'b0, b};
        limit = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
        if (full > limit) begin
            res.carry = 1'b1;
            res.sum   = limit[SAT_MAX_W-1:0];
        end else begin
            res.carry = 1'b0;
            res.sum   = full[SAT_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/power_popcount.sv
// Combinational count of the nets that changed between two consecutive samples.
module power_popcount #(
    parameter int WIDTH = 1,
    parameter int POP_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] prev,
    output logic [POP_W-1:0] count
);

    logic [WIDTH-1:0] diff;

    always_comb begin
        diff  = sample ^ prev;
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + POP_W'(diff[i]);
        end
    end

endmodule

// File: rtl/power_toggle_monitor.sv
// Counts bit toggles on a monitored bus over fixed windows and hands one
// saturating activity count per window to a collector over valid/ready.
module power_toggle_monitor
    import power_mon_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample,
    output logic             act_valid,
    input  logic             act_ready,
    output logic [CNT_W-1:0] act_count,
    output logic             act_sat,
    output logic             busy
);

    localparam int POP_W = $clog2(WIDTH + 1);

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    prev;
    logic [WIN_LOG2-1:0] win;
    logic [CNT_W-1:0]    acc;
    logic                acc_sat;
    logic [POP_W-1:0]    pop;
    sat_result_t         add_res;
    logic [CNT_W-1:0]    acc_next;
    logic                sat_next;
    logic                win_last;

    power_popcount #(
        .WIDTH (WIDTH),
        .POP_W (POP_W)
    ) u_popcount (
        .sample (sample),
        .prev   (prev),
        .count  (pop)
    );

    always_comb begin
        add_res  = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(pop), CNT_W);
        acc_next = CNT_W'(add_res.sum);
        sat_next = acc_sat | add_res.carry;
        win_last = &win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // clear outranks both en and the handshake; dropping en mid-window discards it.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (en) next_state = ARM;
                ARM:     next_state = en ? COUNT : IDLE;
                COUNT: begin
                    if (!en) begin
                        next_state = IDLE;
                    end else if (win_last) begin
                        next_state = HOLD;
                    end
                end
                HOLD:    if (act_ready) next_state = en ? ARM : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        act_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    // The result register is loaded with the accumulator value that includes the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            win       <= '0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            act_count <= '0;
            act_sat   <= 1'b0;
        end else if (clear) begin
            win       <= '0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            act_count <= '0;
            act_sat   <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    prev    <= sample;
                    win     <= '0;
                    acc     <= '0;
                    acc_sat <= 1'b0;
                end
                COUNT: begin
                    if (en) begin
                        prev    <= sample;
                        win     <= win + WIN_LOG2'(1);
                        acc     <= acc_next;
                        acc_sat <= sat_next;
                        if (win_last) begin
                            act_count <= acc_next;
                            act_sat   <= sat_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
